axi_lite_regbank: RTL and testbench
===================================

AXI_LITE_REGBANK -- requirements
Module: axi_lite_regbank

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning AXI data width (32 or 64 only).
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, meaning AXI address width.
REQ-003 SHALL have parameter NUM_CTRL, default 8, meaning count of read/write control registers (1..64).
REQ-004 SHALL have parameter NUM_STAT, default 8, meaning count of read-only status registers (0..64).
REQ-005 SHALL have parameter PULSE_MASK, default 0 (NUM_CTRL bits), meaning bit i set makes control register i self-clearing.
REQ-006 SHALL have port S_AXI_ACLK, input, 1, meaning the single clock.
REQ-007 SHALL have port S_AXI_ARESET, input, 1, meaning reset; one clock, reset synchronous and active-high.
REQ-008 SHALL have AXI4-Lite slave ports AWADDR/AWPROT/AWVALID/AWREADY, WDATA/WSTRB/WVALID/WREADY, BRESP/BVALID/BREADY, ARADDR/ARPROT/ARVALID/ARREADY, RDATA/RRESP/RVALID/RREADY, all prefixed S_AXI_, with standard directions and widths; PROT inputs are ignored.
REQ-009 SHALL have port ctrl_out, output, NUM_CTRL*DATA_WIDTH, meaning flattened control registers, register i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-010 SHALL have port stat_in, input, NUM_STAT*DATA_WIDTH, meaning flattened status values, same packing.
REQ-011 SHALL have port wr_pulse, output, NUM_CTRL, meaning one-cycle strobe, bit i when control register i is written.
REQ-012 SHALL have port rd_pulse, output, max(NUM_STAT,1), meaning one-cycle strobe, bit j when status register j is read.

Function
REQ-013 Address map SHALL be word index k = addr >> log2(DATA_WIDTH/8); k < NUM_CTRL is control register k; NUM_CTRL <= k < NUM_CTRL+NUM_STAT is status register k-NUM_CTRL; anything else is unmapped. Low address bits are ignored.
REQ-014 AW and W SHALL be accepted independently: AWREADY high while no address is held; WREADY high while no data is held. Each handshake latches its payload.
REQ-015 Once both address and data are held and BVALID is low, commit SHALL occur on the next edge. Commit updates the register with byte-lane strobes per WSTRB, pulses wr_pulse for one cycle, and sets BVALID.
REQ-016 BRESP SHALL be OKAY (2'b00) for control registers and SLVERR (2'b10) for status or unmapped addresses; SLVERR writes modify nothing and pulse nothing.
REQ-017 Held address/data SHALL clear on the B handshake, so AWREADY/WREADY re-assert the following cycle; at most one write is outstanding.
REQ-018 ARREADY SHALL be high while RVALID is low. On the AR handshake, RDATA/RRESP SHALL be registered from current values and RVALID SHALL rise the next cycle. RVALID holds with stable data until RREADY.
REQ-019 Reads SHALL return control register value, stat_in slice sampled at the AR-handshake edge, or 0 with SLVERR for unmapped addresses; mapped reads return OKAY.
REQ-020 rd_pulse[j] SHALL assert for one cycle coincident with the AR handshake of status register j.
REQ-021 A read and a commit to the same register on the same edge SHALL return the pre-write value.
REQ-022 A PULSE_MASK register SHALL hold the written value for exactly one cycle, then return to 0; a read never observes a nonzero pulse value unless coincident.
REQ-023 Write and read channels SHALL operate concurrently with no mutual stalls.

Reset
REQ-024 While S_AXI_ARESET is high at an edge, all READY and VALID outputs, BRESP, RRESP, RDATA, ctrl_out, wr_pulse, rd_pulse, and held address/data SHALL be 0. Any transaction in flight is dropped, with no B or R response.
REQ-025 AWREADY, WREADY, and ARREADY SHALL be 1 on the first cycle after reset deasserts.

Verification
REQ-026 AW at 0x04 three cycles before W 0xA5A5_1234 with WSTRB 0xF -> BVALID one cycle after W handshake, BRESP 00, ctrl_out[63:32]=0xA5A51234, wr_pulse=0x02 for one cycle.
REQ-027 Write WSTRB 0x2 data 0xFFFF_FFFF to 0x00, prior value 0 -> register reads 0x0000_FF00.
REQ-028 Defaults, stat_in slice 0 = 0x39, read 0x20 -> RDATA 0x39, RRESP 00, rd_pulse=0x01 at AR handshake; read 0x40 -> RDATA 0, RRESP 10.
REQ-029 PULSE_MASK=0x1, write 0x1 to 0x00 -> ctrl_out[31:0]=1 for one cycle then 0; subsequent read returns 0.
REQ-030 BREADY held low 10 cycles after commit -> BVALID held, AWREADY/WREADY low; reset asserted mid-hold -> all outputs 0, READYs 1 one cycle after release.

Source files
------------

// File: rtl/axi_lite_regbank.sv
// AXI4-Lite register bank: read/write control registers followed by read-only status registers,
// with per-register write/read strobes and optional self-clearing control registers.
module axi_lite_regbank #(
  parameter int                  DATA_WIDTH = 32,
  parameter int                  ADDR_WIDTH = 16,
  parameter int                  NUM_CTRL   = 8,
  parameter int                  NUM_STAT   = 8,
  parameter logic [NUM_CTRL-1:0] PULSE_MASK = '0,
  localparam int                 STAT_W     = (NUM_STAT > 0) ? NUM_STAT : 1,
  localparam int                 STRB_W     = DATA_WIDTH / 8
) (
  input  logic                           S_AXI_ACLK,
  input  logic                           S_AXI_ARESET,

  input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                     S_AXI_AWPROT,
  input  logic                           S_AXI_AWVALID,
  output logic                           S_AXI_AWREADY,

  input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [STRB_W-1:0]              S_AXI_WSTRB,
  input  logic                           S_AXI_WVALID,
  output logic                           S_AXI_WREADY,

  output logic [1:0]                     S_AXI_BRESP,
  output logic                           S_AXI_BVALID,
  input  logic                           S_AXI_BREADY,

  input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                     S_AXI_ARPROT,
  input  logic                           S_AXI_ARVALID,
  output logic                           S_AXI_ARREADY,

  output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                     S_AXI_RRESP,
  output logic                           S_AXI_RVALID,
  input  logic                           S_AXI_RREADY,

  output logic [NUM_CTRL*DATA_WIDTH-1:0] ctrl_out,
  input  logic [STAT_W*DATA_WIDTH-1:0]   stat_in,
  output logic [NUM_CTRL-1:0]            wr_pulse,
  output logic [STAT_W-1:0]              rd_pulse
);

  localparam int         ADDR_LSB    = $clog2(STRB_W);
  localparam int         IDX_W       = ADDR_WIDTH - ADDR_LSB;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic                  r_live;
  logic                  r_awHeld;
  logic [ADDR_WIDTH-1:0] r_awAddr;
  logic                  r_wHeld;
  logic [DATA_WIDTH-1:0] r_wData;
  logic [STRB_W-1:0]     r_wStrb;
  logic                  r_bValid;
  logic [1:0]            r_bResp;
  logic                  r_rValid;
  logic [DATA_WIDTH-1:0] r_rData;
  logic [1:0]            r_rResp;
  logic [NUM_CTRL-1:0]   r_wrPulse;
  logic [DATA_WIDTH-1:0] r_ctrl [NUM_CTRL];

  logic                  w_awHs;
  logic                  w_wHs;
  logic                  w_bHs;
  logic                  w_arHs;
  logic                  w_rHs;
  logic                  w_commit;
  logic [IDX_W-1:0]      w_awIdx;
  logic [IDX_W-1:0]      w_arIdx;
  logic                  w_awIsCtrl;
  logic                  w_arIsCtrl;
  logic                  w_arIsStat;
  logic [NUM_CTRL-1:0]   w_wrSel;
  logic [STAT_W-1:0]     w_rdSel;
  logic [DATA_WIDTH-1:0] w_wMask;
  logic [DATA_WIDTH-1:0] w_rdData;
  logic                  w_unused;

  // r_live keeps every READY low while reset is sampled and for the edge that releases it.
  assign S_AXI_AWREADY = r_live & ~r_awHeld;
  assign S_AXI_WREADY  = r_live & ~r_wHeld;
  assign S_AXI_ARREADY = r_live & ~r_rValid;
  assign S_AXI_BVALID  = r_bValid;
  assign S_AXI_BRESP   = r_bResp;
  assign S_AXI_RVALID  = r_rValid;
  assign S_AXI_RDATA   = r_rData;
  assign S_AXI_RRESP   = r_rResp;
  assign wr_pulse      = r_wrPulse;

  assign w_awHs   = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_wHs    = S_AXI_WVALID & S_AXI_WREADY;
  assign w_bHs    = r_bValid & S_AXI_BREADY;
  assign w_arHs   = S_AXI_ARVALID & S_AXI_ARREADY;
  assign w_rHs    = r_rValid & S_AXI_RREADY;
  assign w_commit = r_awHeld & r_wHeld & ~r_bValid;

  assign w_awIdx    = r_awAddr[ADDR_WIDTH-1:ADDR_LSB];
  assign w_arIdx    = S_AXI_ARADDR[ADDR_WIDTH-1:ADDR_LSB];
  assign w_awIsCtrl = 32'(w_awIdx) < 32'(NUM_CTRL);
  assign w_arIsCtrl = 32'(w_arIdx) < 32'(NUM_CTRL);
  assign w_arIsStat = !w_arIsCtrl && (32'(w_arIdx) < 32'(NUM_CTRL + NUM_STAT));

  assign rd_pulse = w_arHs ? w_rdSel : '0;
  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, r_awAddr[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

  always_comb begin
    w_wrSel = '0;
    for (int i = 0; i < NUM_CTRL; i++) begin
      if (w_awIsCtrl && (32'(w_awIdx) == 32'(i))) w_wrSel[i] = 1'b1;
    end
  end

  always_comb begin
    w_wMask = '0;
    for (int b = 0; b < STRB_W; b++) begin
      w_wMask[b*8 +: 8] = {8{r_wStrb[b]}};
    end
  end

  // Status select is one-hot; unmapped addresses fall through to zero data.
  always_comb begin
    w_rdSel  = '0;
    w_rdData = '0;
    for (int i = 0; i < NUM_CTRL; i++) begin
      if (w_arIsCtrl && (32'(w_arIdx) == 32'(i))) w_rdData = r_ctrl[i];
    end
    for (int j = 0; j < NUM_STAT; j++) begin
      if (32'(w_arIdx) == 32'(NUM_CTRL + j)) begin
        w_rdSel[j] = 1'b1;
        w_rdData   = stat_in[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    ctrl_out = '0;
    for (int i = 0; i < NUM_CTRL; i++) begin
      ctrl_out[i*DATA_WIDTH +: DATA_WIDTH] = r_ctrl[i];
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      r_live    <= 1'b0;
      r_awHeld  <= 1'b0;
      r_awAddr  <= '0;
      r_wHeld   <= 1'b0;
      r_wData   <= '0;
      r_wStrb   <= '0;
      r_bValid  <= 1'b0;
      r_bResp   <= RESP_OKAY;
      r_wrPulse <= '0;
    end else begin
      r_live    <= 1'b1;
      r_wrPulse <= w_commit ? w_wrSel : '0;
      if (w_bHs) begin
        r_awHeld <= 1'b0;
        r_awAddr <= '0;
        r_wHeld  <= 1'b0;
        r_wData  <= '0;
        r_wStrb  <= '0;
      end else begin
        if (w_awHs) begin
          r_awHeld <= 1'b1;
          r_awAddr <= S_AXI_AWADDR;
        end
        if (w_wHs) begin
          r_wHeld <= 1'b1;
          r_wData <= S_AXI_WDATA;
          r_wStrb <= S_AXI_WSTRB;
        end
      end
      if (w_commit) begin
        r_bValid <= 1'b1;
        r_bResp  <= w_awIsCtrl ? RESP_OKAY : RESP_SLVERR;
      end else if (w_bHs) begin
        r_bValid <= 1'b0;
      end
    end
  end

  // Self-clearing registers fall back to zero on every edge that is not their own commit.
  always_ff @(posedge S_AXI_ACLK) begin
    for (int i = 0; i < NUM_CTRL; i++) begin
      if (S_AXI_ARESET) begin
        r_ctrl[i] <= '0;
      end else if (w_commit && w_wrSel[i]) begin
        r_ctrl[i] <= (r_ctrl[i] & ~w_wMask) | (r_wData & w_wMask);
      end else if (PULSE_MASK[i]) begin
        r_ctrl[i] <= '0;
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      r_rValid <= 1'b0;
      r_rData  <= '0;
      r_rResp  <= RESP_OKAY;
    end else if (w_arHs) begin
      r_rValid <= 1'b1;
      r_rData  <= w_rdData;
      r_rResp  <= (w_arIsCtrl || w_arIsStat) ? RESP_OKAY : RESP_SLVERR;
    end else if (w_rHs) begin
      r_rValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_lite_regbank.sv
// Self-checking bench for axi_lite_regbank: directed register scenarios followed by random
// transactions, all checked against an array-based register model.
module tb_axi_lite_regbank;

  localparam int            DW    = 32;
  localparam int            AW    = 16;
  localparam int            NC    = 8;
  localparam int            NS    = 8;
  localparam logic [NC-1:0] PMASK = 8'h80;

  logic             clk = 1'b0;
  logic             areset;
  logic [AW-1:0]    S_AXI_AWADDR;
  logic [2:0]       S_AXI_AWPROT;
  logic             S_AXI_AWVALID;
  logic             S_AXI_AWREADY;
  logic [DW-1:0]    S_AXI_WDATA;
  logic [3:0]       S_AXI_WSTRB;
  logic             S_AXI_WVALID;
  logic             S_AXI_WREADY;
  logic [1:0]       S_AXI_BRESP;
  logic             S_AXI_BVALID;
  logic             S_AXI_BREADY;
  logic [AW-1:0]    S_AXI_ARADDR;
  logic [2:0]       S_AXI_ARPROT;
  logic             S_AXI_ARVALID;
  logic             S_AXI_ARREADY;
  logic [DW-1:0]    S_AXI_RDATA;
  logic [1:0]       S_AXI_RRESP;
  logic             S_AXI_RVALID;
  logic             S_AXI_RREADY;
  logic [NC*DW-1:0] ctrl_out;
  logic [NS*DW-1:0] stat_in;
  logic [NC-1:0]    wr_pulse;
  logic [NS-1:0]    rd_pulse;

  int            cmpCount = 0;
  int            errCount = 0;
  logic [DW-1:0] ctrlModel [NC];

  axi_lite_regbank #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CTRL(NC), .NUM_STAT(NS), .PULSE_MASK(PMASK)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(areset),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .ctrl_out(ctrl_out), .stat_in(stat_in), .wr_pulse(wr_pulse), .rd_pulse(rd_pulse)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    cmpCount++;
    assert (observed === expected) else begin
      errCount++;
      $error("[TB] FAIL %s: observed %0h required %0h", tag, observed, expected);
    end
  endtask

  task automatic reportTimeout(input string tag);
    cmpCount++;
    errCount++;
    $error("[TB] FAIL %s: observed timeout, required a handshake", tag);
  endtask

  function automatic logic [DW-1:0] laneMask(input logic [3:0] strb);
    logic [DW-1:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) if (strb[b]) m[b*8 +: 8] = 8'hFF;
    return m;
  endfunction

  // Control vector as the model sees it, optionally with one register showing a transient value.
  function automatic logic [NC*DW-1:0] ctrlVec(input int hotIdx, input logic [DW-1:0] hotVal);
    logic [NC*DW-1:0] v;
    for (int i = 0; i < NC; i++) v[i*DW +: DW] = (i == hotIdx) ? hotVal : ctrlModel[i];
    return v;
  endfunction

  task automatic applyWrite(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [3:0] strb,
                            input int awDelay, input int wDelay, input int bDelay, input string tag);
    int            idx;
    bit            isCtrl;
    logic [DW-1:0] newVal;
    logic [NC-1:0] expPulse;
    logic [1:0]    expResp;
    int            cyc;
    int            hsCyc;
    bit            awDone;
    bit            wDone;
    bit            awHs;
    bit            wHs;
    idx      = int'(addr) / 4;
    isCtrl   = idx < NC;
    expResp  = isCtrl ? 2'b00 : 2'b10;
    expPulse = '0;
    newVal   = '0;
    if (isCtrl) begin
      expPulse[idx] = 1'b1;
      newVal = (ctrlModel[idx] & ~laneMask(strb)) | (data & laneMask(strb));
    end
    cyc = 0; awDone = 0; wDone = 0;
    S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
    while (!(awDone && wDone)) begin
      if (cyc > 40) begin
        reportTimeout({tag, "_awhs"});
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        return;
      end
      S_AXI_AWVALID = !awDone && (cyc >= awDelay);
      S_AXI_WVALID  = !wDone && (cyc >= wDelay);
      awHs = S_AXI_AWVALID && S_AXI_AWREADY;
      wHs  = S_AXI_WVALID && S_AXI_WREADY;
      tick;
      cyc++;
      if (awHs) awDone = 1;
      if (wHs) wDone = 1;
      if (awHs) S_AXI_AWVALID = 1'b0;
      if (wHs) S_AXI_WVALID = 1'b0;
    end
    hsCyc = cyc;
    while (S_AXI_BVALID !== 1'b1) begin
      if (cyc - hsCyc > 20) begin
        reportTimeout({tag, "_bvalid"});
        return;
      end
      tick;
      cyc++;
    end
    checkOutput({tag, "_blat"}, 256'(cyc - hsCyc), 256'(1));
    checkOutput({tag, "_bresp"}, 256'(S_AXI_BRESP), 256'(expResp));
    checkOutput({tag, "_wrpulse"}, 256'(wr_pulse), 256'(expPulse));
    checkOutput({tag, "_ctrl"}, 256'(ctrl_out), 256'(ctrlVec(isCtrl ? idx : -1, newVal)));
    if (isCtrl && !PMASK[idx]) ctrlModel[idx] = newVal;
    S_AXI_BREADY = (bDelay == 0);
    tick;
    checkOutput({tag, "_wrpulse_clr"}, 256'(wr_pulse), 256'(0));
    checkOutput({tag, "_ctrl_after"}, 256'(ctrl_out), 256'(ctrlVec(-1, '0)));
    if (bDelay > 0) begin
      repeat (bDelay - 1) tick;
      checkOutput({tag, "_bhold"}, 256'({S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY}), 256'(3'b100));
      S_AXI_BREADY = 1'b1;
      tick;
    end
    S_AXI_BREADY = 1'b0;
    checkOutput({tag, "_bdone"}, 256'({S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY}), 256'(3'b011));
  endtask

  task automatic applyRead(input logic [AW-1:0] addr, input int rDelay, input bit forceStat0,
                           input logic [DW-1:0] stat0, input string tag);
    int            idx;
    int            cyc;
    bit            hs;
    logic [DW-1:0] expData;
    logic [1:0]    expResp;
    logic [NS-1:0] expRdPulse;
    logic [NS-1:0] seenPulse;
    logic [NS*DW-1:0] statVec;
    for (int j = 0; j < NS; j++) statVec[j*DW +: DW] = $urandom;
    if (forceStat0) statVec[DW-1:0] = stat0;
    stat_in = statVec;
    idx = int'(addr) / 4;
    expRdPulse = '0;
    if (idx < NC) begin
      expData = ctrlModel[idx]; expResp = 2'b00;
    end else if (idx < NC + NS) begin
      expData = statVec[(idx - NC)*DW +: DW]; expResp = 2'b00;
      expRdPulse[idx - NC] = 1'b1;
    end else begin
      expData = '0; expResp = 2'b10;
    end
    S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1;
    cyc = 0; hs = 0; seenPulse = '0;
    while (!hs) begin
      if (cyc > 20) begin
        reportTimeout({tag, "_arhs"});
        S_AXI_ARVALID = 1'b0;
        return;
      end
      #1;
      hs = (S_AXI_ARREADY === 1'b1);
      seenPulse = rd_pulse;
      tick;
      cyc++;
    end
    S_AXI_ARVALID = 1'b0;
    for (int j = 0; j < NS; j++) stat_in[j*DW +: DW] = $urandom;
    checkOutput({tag, "_rdpulse"}, 256'(seenPulse), 256'(expRdPulse));
    checkOutput({tag, "_rvalid_next"}, 256'(S_AXI_RVALID), 256'(1));
    cyc = 0;
    while (S_AXI_RVALID !== 1'b1) begin
      if (cyc > 20) begin
        reportTimeout({tag, "_rvalid"});
        return;
      end
      tick;
      cyc++;
    end
    checkOutput({tag, "_rdata"}, 256'(S_AXI_RDATA), 256'(expData));
    checkOutput({tag, "_rresp"}, 256'(S_AXI_RRESP), 256'(expResp));
    if (rDelay > 0) begin
      repeat (rDelay) tick;
      checkOutput({tag, "_rhold"}, 256'({S_AXI_RVALID, S_AXI_RDATA}), 256'({1'b1, expData}));
    end
    S_AXI_RREADY = 1'b1;
    tick;
    S_AXI_RREADY = 1'b0;
    checkOutput({tag, "_rdone"}, 256'({S_AXI_RVALID, S_AXI_ARREADY}), 256'(2'b01));
  endtask

  // One random transaction spread over the whole map, including unmapped words and low address bits.
  task automatic applyStimulus(input int n);
    logic [AW-1:0] addr;
    addr = AW'(($urandom_range(0, NC + NS + 3) << 2) | $urandom_range(0, 3));
    if ($urandom_range(0, 1) == 1)
      applyWrite(addr, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 3), $sformatf("rnd%0d_wr", n));
    else
      applyRead(addr, $urandom_range(0, 3), 1'b0, '0, $sformatf("rnd%0d_rd", n));
  endtask

  initial begin
    areset = 1'b1;
    S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
    S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
    stat_in = '0;
    for (int i = 0; i < NC; i++) ctrlModel[i] = '0;
    repeat (3) tick;
    checkOutput("reset_outputs", 256'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID,
                S_AXI_RVALID, S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA, wr_pulse, rd_pulse}), 256'(0));
    checkOutput("reset_ctrl", 256'(ctrl_out), 256'(0));
    areset = 1'b0;
    tick;
    checkOutput("reset_release_ready", 256'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 256'(3'b111));

    applyWrite(16'h0004, 32'hA5A5_1234, 4'hF, 0, 3, 0, "aw_before_w");
    checkOutput("aw_before_w_word1", 256'(ctrl_out[63:32]), 256'(32'hA5A5_1234));
    applyRead(16'h0004, 0, 1'b0, '0, "rd_word1");

    applyWrite(16'h0000, 32'hFFFF_FFFF, 4'h2, 2, 0, 1, "strb_lane1");
    checkOutput("strb_lane1_word0", 256'(ctrl_out[31:0]), 256'(32'h0000_FF00));
    applyRead(16'h0003, 2, 1'b0, '0, "rd_word0");

    applyRead(16'h0020, 1, 1'b1, 32'h39, "rd_stat0");
    applyRead(16'h0040, 0, 1'b0, '0, "rd_unmapped");
    applyRead(16'h0047, 0, 1'b0, '0, "rd_unmapped_low");
    applyRead(16'h003C, 0, 1'b0, '0, "rd_stat7");

    applyWrite(16'h0024, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, "wr_status");
    applyWrite(16'h0050, 32'h1234_5678, 4'hF, 1, 1, 0, "wr_unmapped");

    applyWrite(16'h001C, 32'h0000_0001, 4'hF, 0, 0, 0, "pulse_reg");
    applyRead(16'h001C, 0, 1'b0, '0, "pulse_readback");

    applyWrite(16'h000C, 32'h1111_1111, 4'hF, 0, 0, 0, "pre_same_edge");
    fork
      applyWrite(16'h000C, 32'h2222_2222, 4'hF, 0, 0, 0, "same_edge_wr");
      begin
        tick;
        applyRead(16'h000C, 0, 1'b0, '0, "same_edge_rd");
      end
    join
    applyRead(16'h000C, 0, 1'b0, '0, "same_edge_after");

    fork
      applyWrite(16'h0014, $urandom, 4'hF, 2, 1, 2, "concurrent_wr");
      applyRead(16'h0028, 1, 1'b0, '0, "concurrent_rd");
    join

    for (int n = 0; n < 40; n++) applyStimulus(n);

    // Commit a write, stall the response, then reset in the middle of the stall.
    S_AXI_AWADDR = 16'h0008; S_AXI_WDATA = 32'h0BAD_F00D; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    tick;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    tick;
    ctrlModel[2] = 32'h0BAD_F00D;
    checkOutput("stall_commit_ctrl", 256'(ctrl_out), 256'(ctrlVec(-1, '0)));
    for (int k = 0; k < 10; k++) begin
      tick;
      checkOutput($sformatf("stall_hold%0d", k),
                  256'({S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY}), 256'(3'b100));
    end
    S_AXI_ARADDR = 16'h0008; S_AXI_ARVALID = 1'b1;
    areset = 1'b1;
    tick;
    S_AXI_ARVALID = 1'b0;
    for (int i = 0; i < NC; i++) ctrlModel[i] = '0;
    checkOutput("midreset_outputs", 256'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID,
                S_AXI_RVALID, S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA, wr_pulse, rd_pulse}), 256'(0));
    checkOutput("midreset_ctrl", 256'(ctrl_out), 256'(0));
    tick;
    areset = 1'b0;
    S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
    tick;
    checkOutput("midreset_release", 256'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY,
                S_AXI_BVALID, S_AXI_RVALID}), 256'(5'b11100));
    S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
    applyRead(16'h0008, 0, 1'b0, '0, "post_reset_rd");
    applyWrite(16'h0018, 32'hCAFE_0001, 4'h9, 1, 0, 0, "post_reset_wr");
    applyRead(16'h0018, 0, 1'b0, '0, "post_reset_rdback");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
    $finish;
  end

endmodule
